// File: rtl/pgm_pkg.sv
// Shared types and helpers for the PGM DDRAM arbiter slice.
package pgm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_ISSUE,
    ST_READ_WAIT
  } arb_state_t;

  typedef enum logic [1:0] {
    CL_CPU,
    CL_VID,
    CL_AUD
  } client_t;

  // Byte enables for a 16-bit lane selected by byte address bits [2:1].
  function automatic logic [7:0] be_from_addr(input logic [1:0] lane);
    return 8'h03 << {lane, 1'b0};
  endfunction

endpackage

// File: rtl/pgm_toggle_sync.sv
// Two-flop synchroniser for a toggle request, compared against the local ack.
module pgm_toggle_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic ack_i,
  output logic pending_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= req_i;
      s2_q <= s1_q;
    end
  end

  assign pending_o = s2_q ^ ack_i;

endmodule

// File: rtl/pgm_ddram_arbiter.sv
// DDRAM front end: arbitrates 68k/video/audio toggle-handshake reads, buffers
// loader writes into byte-enabled 64-bit writes, and keeps a one-line 68k cache.
module pgm_ddram_arbiter
  import pgm_pkg::*;
#(
  parameter logic [28:0] DDR_BASE       = 29'h0,
  parameter logic [7:0]  LOADER_INDEX   = 8'h00,
  parameter int unsigned AUDIO_MAX_WAIT = 64
) (
  input  logic        fixed_50m_clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [26:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  input  logic [7:0]  ioctl_index,
  input  logic        cpu_req,
  input  logic [23:1] cpu_addr,
  output logic        cpu_ack,
  output logic [63:0] cpu_rdata,
  input  logic        vid_req,
  input  logic [28:0] vid_addr,
  output logic        vid_ack,
  output logic [63:0] vid_rdata,
  input  logic        aud_req,
  input  logic [28:0] aud_addr,
  output logic        aud_ack,
  output logic [63:0] aud_rdata,
  output logic        ddram_rd,
  output logic        ddram_we,
  output logic [28:0] ddram_addr,
  output logic [63:0] ddram_din,
  output logic [7:0]  ddram_be,
  input  logic [63:0] ddram_dout,
  input  logic        ddram_busy,
  input  logic        ddram_dout_ready,
  output logic        wr_overflow
);

  localparam int unsigned   WW       = $clog2(AUDIO_MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(AUDIO_MAX_WAIT);

  arb_state_t state_q, state_d;
  client_t    cl_q;
  logic [28:0] rd_addr_q;
  logic [20:0] rd_tag_q;

  logic        wb_full_q;
  logic [28:0] wb_addr_q;
  logic [63:0] wb_din_q;
  logic [7:0]  wb_be_q;
  logic        ovf_q;

  logic        cache_valid_q;
  logic [20:0] cache_tag_q;
  logic [63:0] cache_data_q;
  logic        dl_q;
  logic [WW-1:0] aud_wait_q;

  logic        cpu_ack_q, vid_ack_q, aud_ack_q;
  logic [63:0] cpu_rdata_q, vid_rdata_q, aud_rdata_q;

  logic cpu_pend, vid_pend, aud_pend;
  logic cpu_hit, aud_inflight, capture;
  logic grant, hit, wr_done, rd_done;
  client_t grant_cl;
  logic [28:0] grant_addr;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{ioctl_addr[0], cpu_addr[2:1]};

  pgm_toggle_sync u_cpu_sync (
    .clk_i(fixed_50m_clk), .rst_ni(reset_n),
    .req_i(cpu_req), .ack_i(cpu_ack_q), .pending_o(cpu_pend)
  );
  pgm_toggle_sync u_vid_sync (
    .clk_i(fixed_50m_clk), .rst_ni(reset_n),
    .req_i(vid_req), .ack_i(vid_ack_q), .pending_o(vid_pend)
  );
  pgm_toggle_sync u_aud_sync (
    .clk_i(fixed_50m_clk), .rst_ni(reset_n),
    .req_i(aud_req), .ack_i(aud_ack_q), .pending_o(aud_pend)
  );

  assign cpu_hit      = cache_valid_q && (cache_tag_q == cpu_addr[23:3]);
  assign aud_inflight = (state_q != ST_IDLE) && (cl_q == CL_AUD);
  assign capture      = ioctl_wr && ioctl_download && (ioctl_index == LOADER_INDEX);

  always_ff @(posedge fixed_50m_clk) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant      = 1'b0;
    grant_cl   = CL_CPU;
    grant_addr = '0;
    hit        = 1'b0;
    wr_done    = 1'b0;
    rd_done    = 1'b0;
    ddram_rd   = 1'b0;
    ddram_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_full_q) begin
          state_d = ST_WRITE;
        end else if (!ioctl_download) begin
          if (cpu_pend && cpu_hit) begin
            hit = 1'b1;
          end else if (aud_pend && (aud_wait_q == WAIT_MAX)) begin
            grant = 1'b1; grant_cl = CL_AUD;
          end else if (cpu_pend) begin
            grant = 1'b1; grant_cl = CL_CPU;
          end else if (vid_pend) begin
            grant = 1'b1; grant_cl = CL_VID;
          end else if (aud_pend) begin
            grant = 1'b1; grant_cl = CL_AUD;
          end
        end
        if (grant) state_d = ST_READ_ISSUE;
      end
      ST_WRITE: begin
        ddram_we = 1'b1;
        if (!ddram_busy) begin
          wr_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_READ_ISSUE: begin
        ddram_rd = 1'b1;
        if (!ddram_busy) state_d = ST_READ_WAIT;
      end
      ST_READ_WAIT: begin
        if (ddram_dout_ready) begin
          rd_done = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    case (grant_cl)
      CL_CPU:  grant_addr = DDR_BASE + {8'b0, cpu_addr[23:3]};
      CL_VID:  grant_addr = DDR_BASE + vid_addr;
      default: grant_addr = DDR_BASE + aud_addr;
    endcase
  end

  always_ff @(posedge fixed_50m_clk) begin
    if (!reset_n) begin
      cl_q          <= CL_CPU;
      rd_addr_q     <= '0;
      rd_tag_q      <= '0;
      wb_full_q     <= 1'b0;
      wb_addr_q     <= '0;
      wb_din_q      <= '0;
      wb_be_q       <= '0;
      ovf_q         <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_tag_q   <= '0;
      cache_data_q  <= '0;
      dl_q          <= 1'b0;
      aud_wait_q    <= '0;
      cpu_ack_q     <= 1'b0;
      vid_ack_q     <= 1'b0;
      aud_ack_q     <= 1'b0;
      cpu_rdata_q   <= '0;
      vid_rdata_q   <= '0;
      aud_rdata_q   <= '0;
    end else begin
      dl_q <= ioctl_download;

      if (wr_done) begin
        wb_full_q <= 1'b0;
        if (wb_addr_q == DDR_BASE + {8'b0, cache_tag_q}) cache_valid_q <= 1'b0;
      end
      if (capture) begin
        if (wb_full_q) begin
          ovf_q <= 1'b1;
        end else begin
          wb_full_q <= 1'b1;
          wb_addr_q <= DDR_BASE + {5'b0, ioctl_addr[26:3]};
          wb_din_q  <= {4{ioctl_dout}};
          wb_be_q   <= be_from_addr(ioctl_addr[2:1]);
        end
      end

      if (grant) begin
        cl_q      <= grant_cl;
        rd_addr_q <= grant_addr;
        rd_tag_q  <= cpu_addr[23:3];
      end

      if (hit) begin
        cpu_ack_q   <= ~cpu_ack_q;
        cpu_rdata_q <= cache_data_q;
      end

      if (rd_done) begin
        case (cl_q)
          CL_CPU: begin
            cpu_ack_q   <= ~cpu_ack_q;
            cpu_rdata_q <= ddram_dout;
            cache_tag_q <= rd_tag_q;
            cache_data_q <= ddram_dout;
            // Data fetched while the loader is active may already be stale.
            cache_valid_q <= !ioctl_download;
          end
          CL_VID: begin
            vid_ack_q   <= ~vid_ack_q;
            vid_rdata_q <= ddram_dout;
          end
          default: begin
            aud_ack_q   <= ~aud_ack_q;
            aud_rdata_q <= ddram_dout;
          end
        endcase
      end

      if (ioctl_download && !dl_q) cache_valid_q <= 1'b0;

      if (!aud_pend || (grant && grant_cl == CL_AUD)) aud_wait_q <= '0;
      else if (!aud_inflight && aud_wait_q != WAIT_MAX) aud_wait_q <= aud_wait_q + 1'b1;
    end
  end

  assign cpu_ack     = cpu_ack_q;
  assign vid_ack     = vid_ack_q;
  assign aud_ack     = aud_ack_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign vid_rdata   = vid_rdata_q;
  assign aud_rdata   = aud_rdata_q;
  assign ddram_addr  = (state_q == ST_WRITE) ? wb_addr_q : rd_addr_q;
  assign ddram_din   = (state_q == ST_WRITE) ? wb_din_q : '0;
  assign ddram_be    = (state_q == ST_WRITE) ? wb_be_q : '0;
  assign wr_overflow = ovf_q;

endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// Directed bench for pgm_ddram_arbiter with a small DDRAM read responder.
module tb_pgm_ddram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download, ioctl_wr;
  logic [26:0] ioctl_addr;
  logic [15:0] ioctl_dout;
  logic [7:0]  ioctl_index;
  logic        cpu_req, vid_req, aud_req;
  logic [23:1] cpu_addr;
  logic [28:0] vid_addr, aud_addr;
  logic        cpu_ack, vid_ack, aud_ack;
  logic [63:0] cpu_rdata, vid_rdata, aud_rdata;
  logic        ddram_rd, ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic [63:0] ddram_dout = '0;
  logic        ddram_busy;
  logic        ddram_dout_ready = 1'b0;
  logic        wr_overflow;

  int vectors = 0;
  int miscompares = 0;

  int          lat = 3;
  int          cd = 0;
  logic [63:0] data_q = '0;
  logic [28:0] log_q[$];
  logic        both_hi = 1'b0;

  always #5 clk = ~clk;

  pgm_ddram_arbiter #(
    .DDR_BASE(29'h0), .LOADER_INDEX(8'h00), .AUDIO_MAX_WAIT(64)
  ) dut (
    .fixed_50m_clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_ack(aud_ack), .aud_rdata(aud_rdata),
    .ddram_rd(ddram_rd), .ddram_we(ddram_we), .ddram_addr(ddram_addr),
    .ddram_din(ddram_din), .ddram_be(ddram_be), .ddram_dout(ddram_dout),
    .ddram_busy(ddram_busy), .ddram_dout_ready(ddram_dout_ready),
    .wr_overflow(wr_overflow)
  );

  function automatic logic [63:0] data_for(input logic [28:0] a);
    if (a == 29'h20000) return 64'h1122334455667788;
    return {3'b0, a, ~{3'b0, a}};
  endfunction

  // DDRAM model: accepts a read on any cycle with rd && !busy, answers after lat cycles.
  always @(negedge clk) begin
    ddram_dout_ready = 1'b0;
    if (ddram_rd && ddram_we) both_hi = 1'b1;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        ddram_dout_ready = 1'b1;
        ddram_dout = data_q;
      end
    end
    if (ddram_rd && !ddram_busy) begin
      log_q.push_back(ddram_addr);
      data_q = data_for(ddram_addr);
      cd = lat;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic get_ack(input int w);
    case (w)
      0: return cpu_ack;
      1: return vid_ack;
      default: return aud_ack;
    endcase
  endfunction

  task automatic wait_ack(input string tag, input int w, input logic exp, input int budget);
    int n = 0;
    while (get_ack(w) !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'b0, get_ack(w)}, {63'b0, exp});
  endtask

  task automatic wait_rd(input string tag, input int budget);
    int n = 0;
    while (ddram_rd !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {63'b0, ddram_rd}, 64'd1);
  endtask

  function automatic logic [23:1] cpu_word(input logic [23:0] byte_addr);
    return byte_addr[23:1];
  endfunction

  initial begin
    int lc, weh, nvid;
    logic we_again;

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = 8'h00; cpu_req = 1'b0; vid_req = 1'b0; aud_req = 1'b0;
    cpu_addr = '0; vid_addr = '0; aud_addr = '0; ddram_busy = 1'b0;
    tick(3);
    check("rst_acks", {61'b0, cpu_ack, vid_ack, aud_ack}, 64'd0);
    check("rst_cpu_rdata", cpu_rdata, 64'd0);
    check("rst_rdata_va", vid_rdata | aud_rdata, 64'd0);
    check("rst_ctrl", {61'b0, ddram_rd, ddram_we, wr_overflow}, 64'd0);
    check("rst_addr_be", {27'b0, ddram_addr, ddram_be}, 64'd0);
    check("rst_din", ddram_din, 64'd0);
    reset_n = 1'b1;
    tick(2);

    // 1: CPU miss, then hit on the same line with fixed 3-cycle latency
    lc = log_q.size();
    cpu_addr = cpu_word(24'h100000);
    cpu_req = 1'b1;
    wait_ack("cpu_miss_ack", 0, 1'b1, 60);
    check("cpu_miss_nrd", 64'(log_q.size() - lc), 64'd1);
    check("cpu_miss_addr", {35'b0, log_q[lc]}, 64'h20000);
    check("cpu_miss_data", cpu_rdata, 64'h1122334455667788);
    cpu_addr = cpu_word(24'h100006);
    cpu_req = 1'b0;
    tick(2);
    check("cpu_hit_early", {63'b0, cpu_ack}, 64'd1);
    tick(1);
    check("cpu_hit_ack", {63'b0, cpu_ack}, 64'd0);
    check("cpu_hit_nrd", 64'(log_q.size() - lc), 64'd1);
    check("cpu_hit_data", cpu_rdata, 64'h1122334455667788);

    // 2: loader write held off by busy, plus an overflowing second write
    ioctl_download = 1'b1;
    ddram_busy = 1'b1;
    ioctl_addr = 27'h12; ioctl_dout = 16'hABCD; ioctl_wr = 1'b1;
    tick(1);
    ioctl_wr = 1'b0;
    weh = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ddram_we) begin
        weh++;
        if (weh == 1) begin
          check("wr_addr", {35'b0, ddram_addr}, 64'd2);
          check("wr_be", {56'b0, ddram_be}, 64'h0C);
          check("wr_din", ddram_din, {4{16'hABCD}});
          ioctl_addr = 27'h14; ioctl_dout = 16'h5555; ioctl_wr = 1'b1;
        end else begin
          ioctl_wr = 1'b0;
        end
        if (weh == 6) ddram_busy = 1'b0;
      end else if (weh > 0) begin
        break;
      end
    end
    ioctl_wr = 1'b0;
    check("wr_we_cycles", 64'(weh), 64'd6);
    check("wr_overflow", {63'b0, wr_overflow}, 64'd1);
    we_again = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ddram_we) we_again = 1'b1;
    end
    check("wr_dropped", {63'b0, we_again}, 64'd0);
    ioctl_download = 1'b0;
    tick(2);

    // 3: simultaneous requests served CPU, video, audio
    lc = log_q.size();
    cpu_addr = cpu_word(24'h200000);
    vid_addr = 29'h1234;
    aud_addr = 29'h5678;
    cpu_req = ~cpu_req; vid_req = ~vid_req; aud_req = ~aud_req;
    wait_ack("tri_aud_ack", 2, aud_req, 200);
    tick(10);
    check("tri_nrd", 64'(log_q.size() - lc), 64'd3);
    check("tri_first", {35'b0, log_q[lc]}, 64'h40000);
    check("tri_second", {35'b0, log_q[lc+1]}, 64'h1234);
    check("tri_third", {35'b0, log_q[lc+2]}, 64'h5678);
    check("tri_acks", {61'b0, cpu_ack, vid_ack, aud_ack}, {61'b0, cpu_req, vid_req, aud_req});
    check("tri_cpu_data", cpu_rdata, data_for(29'h40000));
    check("tri_vid_data", vid_rdata, data_for(29'h1234));
    check("tri_aud_data", aud_rdata, data_for(29'h5678));

    // 4: audio still gets through while video re-requests back to back
    aud_addr = 29'h777;
    vid_addr = 29'h100;
    nvid = 0;
    aud_req = ~aud_req;
    vid_req = ~vid_req;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (aud_ack == aud_req) break;
      if (vid_ack == vid_req) begin
        nvid++;
        vid_addr = 29'(29'h100 + nvid);
        vid_req = ~vid_req;
      end
    end
    check("starve_aud_ack", {63'b0, aud_ack}, {63'b0, aud_req});
    check("starve_aud_data", aud_rdata, data_for(29'h777));
    wait_ack("starve_vid_done", 1, vid_req, 100);
    tick(4);

    // 5: download rises while a CPU read is in flight
    lc = log_q.size();
    cpu_addr = cpu_word(24'h300000);
    cpu_req = ~cpu_req;
    wait_rd("dl_rd_seen", 60);
    tick(1);
    ioctl_download = 1'b1;
    wait_ack("dl_cpu_ack", 0, cpu_req, 60);
    check("dl_cpu_data", cpu_rdata, data_for(29'h60000));
    tick(3);
    ioctl_download = 1'b0;
    tick(2);
    cpu_addr = cpu_word(24'h300002);
    cpu_req = ~cpu_req;
    wait_ack("dl_reread_ack", 0, cpu_req, 60);
    check("dl_reread_nrd", 64'(log_q.size() - lc), 64'd2);
    check("dl_reread_addr", {35'b0, log_q[lc+1]}, 64'h60000);

    // 6: reset during READ_WAIT; the late read data must be ignored
    lat = 6;
    lc = log_q.size();
    cpu_addr = cpu_word(24'h400000);
    cpu_req = ~cpu_req;
    wait_rd("rstw_rd_seen", 60);
    tick(2);
    reset_n = 1'b0;
    cpu_req = 1'b0; vid_req = 1'b0; aud_req = 1'b0;
    tick(1);
    check("rstw_acks", {61'b0, cpu_ack, vid_ack, aud_ack}, 64'd0);
    check("rstw_ctrl", {61'b0, ddram_rd, ddram_we, wr_overflow}, 64'd0);
    check("rstw_addr", {35'b0, ddram_addr}, 64'd0);
    check("rstw_rdata", cpu_rdata | vid_rdata | aud_rdata, 64'd0);
    tick(1);
    reset_n = 1'b1;
    tick(8);
    check("late_ack", {63'b0, cpu_ack}, 64'd0);
    check("late_rdata", cpu_rdata, 64'd0);
    check("late_nrd", 64'(log_q.size() - lc), 64'd1);

    check("rd_we_exclusive", {63'b0, both_hi}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
